// File: rtl/adc_scan_scheduler_if.sv
// ADC-side and result-side signal bundle of adc_scan_scheduler.
// The master is the scheduler; the slave is the ADC and the result consumer.
interface adc_scan_scheduler_if #(
  parameter int CHW = 2,
  parameter int DW  = 10
) ();
  logic [CHW-1:0] ch_sel;
  logic           st_conv;
  logic           adc_done;
  logic [DW-1:0]  adc_result;
  logic [DW-1:0]  result_data;
  logic [CHW-1:0] result_ch;
  logic           result_valid;

  modport master (
    output ch_sel, st_conv, result_data, result_ch, result_valid,
    input  adc_done, adc_result
  );

  modport slave (
    input  ch_sel, st_conv, result_data, result_ch, result_valid,
    output adc_done, adc_result
  );
endinterface

// File: rtl/adc_scan_scheduler.sv
// Periodic multi-channel scan sequencer sharing one SAR ADC among NCH muxed inputs.
// Define ADC_SCHED_AVG4_EN to convert every channel four times and return the truncated average.
module adc_scan_scheduler #(
  parameter int NCH     = 4,
  parameter int CHW     = $clog2(NCH),
  parameter int DW      = 10,
  parameter int SETTLE  = 4,
  parameter int ST_W    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 scan_en,
  input  logic [NCH-1:0]       ch_mask,
  input  logic [15:0]          period,
  input  logic                 clr_flags,
  output logic                 busy,
  output logic                 overrun,
  output logic                 err_timeout,
  adc_scan_scheduler_if.master bus
);

  localparam int CNT_MAX = (TIMEOUT > SETTLE) ? ((TIMEOUT > ST_W) ? TIMEOUT : ST_W)
                                              : ((SETTLE > ST_W) ? SETTLE : ST_W);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] ST_LAST     = CNT_W'(ST_W - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_START, S_WAIT, S_STORE, S_NEXT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CHW-1:0]   ch_sel_q, ch_sel_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [15:0]      timer_q, timer_d;
  logic             expire_q, expire_d;
  logic             armed_q, armed_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             sync3_q, sync3_d;
  logic             edge_q, edge_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CHW-1:0]   res_ch_q, res_ch_d;
  logic             overrun_q, overrun_d;
  logic             err_q, err_d;

  logic             start_scan;
  logic             set_timeout;
  logic             next_found;
  logic [CHW-1:0]   next_ch;
  logic             low_found;
  logic [CHW-1:0]   low_ch;

`ifdef ADC_SCHED_AVG4_EN
  logic [DW+1:0]    acc_q, acc_d, acc_sum;
  logic [1:0]       rep_q, rep_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ch_sel_q  <= '0;
      mask_q    <= '0;
      timer_q   <= '0;
      expire_q  <= 1'b0;
      armed_q   <= 1'b1;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      sync3_q   <= 1'b0;
      edge_q    <= 1'b0;
      data_q    <= '0;
      res_ch_q  <= '0;
      overrun_q <= 1'b0;
      err_q     <= 1'b0;
`ifdef ADC_SCHED_AVG4_EN
      acc_q     <= '0;
      rep_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ch_sel_q  <= ch_sel_d;
      mask_q    <= mask_d;
      timer_q   <= timer_d;
      expire_q  <= expire_d;
      armed_q   <= armed_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      sync3_q   <= sync3_d;
      edge_q    <= edge_d;
      data_q    <= data_d;
      res_ch_q  <= res_ch_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
`ifdef ADC_SCHED_AVG4_EN
      acc_q     <= acc_d;
      rep_q     <= rep_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ch_sel_d    = ch_sel_q;
    mask_d      = mask_q;
    timer_d     = timer_q;
    armed_d     = armed_q;
    data_d      = data_q;
    res_ch_d    = res_ch_q;
    start_scan  = 1'b0;
    set_timeout = 1'b0;
    sync1_d     = bus.adc_done;
    sync2_d     = sync1_q;
    sync3_d     = sync2_q;
    edge_d      = sync2_q & ~sync3_q;
`ifdef ADC_SCHED_AVG4_EN
    acc_d       = acc_q;
    rep_d       = rep_q;
    acc_sum     = acc_q + {2'b00, bus.adc_result};
`endif

    // Descending loops leave the lowest qualifying channel as the final assignment.
    low_found  = 1'b0;
    low_ch     = '0;
    next_found = 1'b0;
    next_ch    = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        low_found = 1'b1;
        low_ch    = CHW'(i);
      end
      if (mask_q[i] && (CHW'(i) > ch_sel_q)) begin
        next_found = 1'b1;
        next_ch    = CHW'(i);
      end
    end

    if (!scan_en) begin
      armed_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (scan_en && ((timer_q == '0) || armed_q) && low_found) begin
          start_scan = 1'b1;
          mask_d     = ch_mask;
          ch_sel_d   = low_ch;
          armed_d    = 1'b0;
          cnt_d      = '0;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
`ifdef ADC_SCHED_AVG4_EN
        acc_d = '0;
        rep_d = '0;
`endif
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_START: begin
        if (cnt_q == ST_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (edge_q) begin
`ifdef ADC_SCHED_AVG4_EN
          if (rep_q == 2'd3) begin
            data_d   = acc_sum[DW+1:2];
            res_ch_d = ch_sel_q;
            state_d  = S_STORE;
          end else begin
            acc_d   = acc_sum;
            rep_d   = rep_q + 2'd1;
            cnt_d   = '0;
            state_d = S_START;
          end
`else
          data_d   = bus.adc_result;
          res_ch_d = ch_sel_q;
          state_d  = S_STORE;
`endif
        end else if (cnt_q == TO_LAST) begin
          set_timeout = 1'b1;
          state_d     = S_NEXT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STORE: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (scan_en && next_found) begin
          ch_sel_d = next_ch;
          cnt_d    = '0;
          state_d  = S_SETTLE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reloading with period-1 makes the next start land exactly period cycles later.
    if (start_scan) begin
      timer_d = (period == 16'd0) ? 16'd0 : period - 16'd1;
    end else if (timer_q != 16'd0) begin
      timer_d = timer_q - 16'd1;
    end
    expire_d = (timer_q == 16'd1) && !start_scan;

    overrun_d = (expire_q && (state_q != S_IDLE)) ? 1'b1 :
                clr_flags                         ? 1'b0 : overrun_q;
    err_d     = set_timeout ? 1'b1 :
                clr_flags   ? 1'b0 : err_q;
  end

  always_comb begin
    busy             = (state_q != S_IDLE);
    overrun          = overrun_q;
    err_timeout      = err_q;
    bus.ch_sel       = ch_sel_q;
    bus.st_conv      = (state_q == S_START);
    bus.result_valid = (state_q == S_STORE);
    bus.result_data  = data_q;
    bus.result_ch    = res_ch_q;
  end

endmodule

// File: doc/adc_scan_scheduler.md
# adc_scan_scheduler

Synchronous sequencer that shares one SAR ADC conversion engine (`adc_fsm_10b_v1` plus comparator) among up to `NCH` multiplexed analog channels. Each scan visits every enabled channel in ascending order: it drives the mux select, waits a settle time, pulses `st_conv` and waits for `adc_done`. It then returns the result tagged with its channel number. Scans repeat on a programmable period, and overrun and timeout are flagged. The block sits between the ADC FSM and the digital back end.

## Interface
- `NCH`, 4: number of channels, 2..16.
- `CHW`, 2: channel index width, `$clog2(NCH)`.
- `DW`, 10: ADC result width.
- `SETTLE`, 4: mux settle cycles before `st_conv`, ≥1.
- `ST_W`, 2: `st_conv` pulse width in cycles, ≥1.
- `TIMEOUT`, 255: maximum wait cycles for `adc_done`, ≤255.

Ports (name, direction, width, meaning):
- `clk` in 1: the block's single clock.
- `rst` in 1: synchronous, active-high reset.
- `scan_en` in 1: enables periodic scanning.
- `ch_mask` in NCH: channel enables, latched at scan start.
- `period` in 16: scan period in clk cycles.
- `clr_flags` in 1: clears the sticky flags.
- `adc_done` in 1: ADC end-of-conversion, asynchronous to `clk`.
- `adc_result` in DW: ADC result, stable while `adc_done` is high.
- `ch_sel` out CHW: analog mux select.
- `st_conv` out 1: start-of-conversion pulse to the ADC.
- `result_data` out DW: converted value.
- `result_ch` out CHW: channel tag for `result_data`.
- `result_valid` out 1: 1-cycle strobe marking `result_data`/`result_ch` valid.
- `busy` out 1: high in any state other than IDLE.
- `overrun` out 1: sticky; the period expired while a scan was still running.
- `err_timeout` out 1: sticky; `adc_done` was not seen within `TIMEOUT` cycles.

## Operation
- **States:** IDLE, SETTLE, START, WAIT, STORE, NEXT.
- **IDLE:**
  - A scan starts when `scan_en`=1, the latched period timer has expired (or this is the first scan after `scan_en` rises) and `ch_mask`≠0.
  - On start: latch `ch_mask`, pick the lowest set bit, load `ch_sel`, reload the period timer with `period`, go to SETTLE.
  - With `ch_mask`=0 the block stays in IDLE and issues no `st_conv`.
- **SETTLE:** hold for `SETTLE` cycles, then go to START.
- **START:** drive `st_conv`=1 for `ST_W` cycles, then go to WAIT and clear the wait counter.
- **WAIT:**
  - `adc_done` passes through a 2-flop synchronizer followed by a rising-edge detector.
  - On an edge: capture `adc_result` and go to STORE.
  - If the wait counter reaches `TIMEOUT` first: set `err_timeout`, discard the channel and go to NEXT.
- **STORE:** `result_valid`=1 for one cycle, with `result_ch`=`ch_sel` and the captured data. Then go to NEXT.
- **NEXT:**
  - If `scan_en`=0 → IDLE (the scan is aborted cleanly after the current conversion).
  - Else, if a higher-numbered latched mask bit is set → load it into `ch_sel`, go to SETTLE.
  - Otherwise the scan is complete → IDLE.
- **Period timer:**
  - Free-running down-counter, reloaded at scan start.
  - If it reaches 0 while `busy`=1: set `overrun`; the next scan starts on the first IDLE cycle.
  - `period`=0 means back-to-back scans.
- **Sticky flags:** `overrun` and `err_timeout` are cleared by `rst` or `clr_flags`. If a set and a clear occur in the same cycle, set wins.
- **Data hold:** `result_data` and `result_ch` hold their values between strobes.

## Timing
- **Reset:** on a `rst` clk edge, every output is 0, the state is IDLE, the timers are 0 and the synchronizer is cleared. This holds even mid-conversion. An ADC edge that arrives late after reset is ignored because the block is in IDLE.
- **Scan start latency:** `ch_sel` is valid on the cycle after the start decision.
- **`st_conv` timing:** `st_conv` rises `SETTLE` cycles after `ch_sel` changes and stays high for exactly `ST_W` cycles.
- **Done-to-strobe latency:** `result_valid` asserts 4 clk edges after the first edge that samples `adc_done` high (sync1, sync2, edge, STORE).
- **Per-channel minimum:** SETTLE + ST_W + 3 + 1 + 1 cycles, plus the ADC conversion time.
- **`adc_done` already high on entry to WAIT:** this is not an edge, so the block waits for a new rising edge or times out.

## Configuration
- **`ADC_SCHED_AVG4_EN` defined:**
  - Each channel is converted 4 times back-to-back: one SETTLE, then START/WAIT repeated 4 times.
  - Results are accumulated in DW+2 bits, and `result_data` = `acc[DW+1:2]` (truncating average).
  - There is one `result_valid` per channel.
  - A timeout on any of the 4 conversions discards the whole channel.
- **Undefined:** single conversion per channel, as described above.

## Test plan
- **Full scan:**
  - Setup: `ch_mask`=4'b1011, `period`=200, ADC model returns 100+ch.
  - Required: three strobes in order, (ch0,100), (ch1,101), (ch3,103).
  - Required: the next scan starts 200 cycles after the first.
- **Empty mask:** `ch_mask`=0 with `scan_en`=1 → `st_conv` never pulses, `busy`=0.
- **Timeout:**
  - Stimulus: ADC model suppresses `adc_done` on ch1.
  - Required: `err_timeout`=1 after 255 WAIT cycles, no strobe for ch1, ch2 is still converted.
  - Required: `clr_flags` clears `err_timeout`.
- **Overrun:**
  - Stimulus: `period`=20 with a 30-cycle ADC.
  - Required: `overrun` is set, and the next scan begins the cycle after IDLE is reached.
- **Reset in WAIT:**
  - Stimulus: assert `rst` while in WAIT, then let `adc_done` rise.
  - Required: all outputs are 0 and there is no `result_valid`.
- **AVG4 build:**
  - Stimulus: ADC returns 10, 11, 12, 13 on ch0.
  - Required: a single strobe with `result_data`=11.
